udp_frame_gen: RTL

//  Periodic Ethernet/IPv4/UDP test-frame generator driving the 10G MAC TX AXI4-Stream (64-bit).

---
 rtl/udp_frame_gen.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/udp_frame_gen.sv
// Periodic Ethernet/IPv4/UDP test-frame generator on a 64-bit AXI4-Stream (MAC TX side).
// Define UDP_FRAME_GEN_STALL_STAT_EN to add the stat_stall back-pressure cycle counter.
module udp_frame_gen #(
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 64,
    parameter int unsigned MAX_PAYLOAD_WORDS      = 256,
    parameter int unsigned CNT_WIDTH              = 32
) (
    input  logic                                m00_axis_aclk,
    input  logic                                m00_axis_aresetn,
    input  logic                                cfg_enable,
    input  logic [CNT_WIDTH-1:0]                cfg_interval,
    input  logic [15:0]                         cfg_payload_words,
    input  logic [47:0]                         cfg_dst_mac,
    input  logic [47:0]                         cfg_src_mac,
    input  logic [31:0]                         cfg_src_ip,
    input  logic [31:0]                         cfg_dst_ip,
    input  logic [15:0]                         cfg_src_port,
    input  logic [15:0]                         cfg_dst_port,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tkeep,
    output logic                                m00_axis_tvalid,
    output logic                                m00_axis_tlast,
    input  logic                                m00_axis_tready,
    output logic [CNT_WIDTH-1:0]                stat_sent,
    output logic [CNT_WIDTH-1:0]                stat_overrun,
`ifdef UDP_FRAME_GEN_STALL_STAT_EN
    output logic [CNT_WIDTH-1:0]                stat_stall,
`endif
    output logic                                stat_busy
);

    typedef enum logic [1:0] {StIdle, StCalc, StSend} state_e;
    // Element k holds frame byte k of the 42-byte Ethernet/IP/UDP header.
    typedef logic [41:0][7:0] hdr_t;

    localparam logic [15:0] MaxWords = 16'(MAX_PAYLOAD_WORDS);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] timer_q, timer_d, sent_q, sent_d, overrun_q, overrun_d;
    logic [CNT_WIDTH-1:0] ival;
    logic [63:0]          seq_q, seq_d, tdata_q, tdata_d;
    logic [15:0]          beat_q, beat_d, n_q, n_d, n_clamp, beat_nxt;
    hdr_t                 hdr_q, hdr_d, hdr_calc;
    logic [7:0]           tkeep_q, tkeep_d;
    logic                 tlast_q, tlast_d, tvalid_q, tvalid_d, fire;

    function automatic hdr_t build_hdr(input logic [47:0] dmac, smac, input logic [31:0] sip, dip,
                                       input logic [15:0] sport, dport, id, n);
        logic [15:0]  totlen, udplen, csum;
        logic [31:0]  sum;
        logic [335:0] v;
        totlen = 16'd28 + {n[12:0], 3'b000};
        udplen = 16'd8 + {n[12:0], 3'b000};
        sum = 32'h4500 + 32'(totlen) + 32'(id) + 32'h4000 + 32'h4011 + 32'(sip[31:16]) +
              32'(sip[15:0]) + 32'(dip[31:16]) + 32'(dip[15:0]);
        sum = 32'(sum[15:0]) + 32'(sum[31:16]);
        sum = 32'(sum[15:0]) + 32'(sum[31:16]);
        csum = ~sum[15:0];
        v = {dmac, smac, 16'h0800, 16'h4500, totlen, id, 16'h4000, 8'h40, 8'h11, csum,
             sip, dip, sport, dport, udplen, 16'h0000};
        // First wire byte sits in the MSBs of v; reverse so byte k lands in element k.
        return hdr_t'({<<8{v}});
    endfunction

    function automatic logic [63:0] pay_word(input logic [63:0] seq, input logic [15:0] idx);
        return (idx == 16'd0) ? seq : {48'd0, idx};
    endfunction

    // Payload words start at byte 42, so every payload beat carries the last two bytes of the
    // previous item in its low lanes and the first six bytes of the current word above them.
    function automatic logic [63:0] beat_data(input hdr_t h, input logic [63:0] seq,
                                              input logic [15:0] n, b);
        logic [63:0] d, w;
        d = '0;
        w = '0;
        if (b < 16'd5) begin
            case (b[2:0])
                3'd0:    d = h[7:0];
                3'd1:    d = h[15:8];
                3'd2:    d = h[23:16];
                3'd3:    d = h[31:24];
                default: d = h[39:32];
            endcase
        end else begin
            if (b == 16'd5) begin
                d[15:0] = {h[41], h[40]};
            end else begin
                w = pay_word(seq, b - 16'd6);
                d[15:0] = {w[7:0], w[15:8]};
            end
            if (b - 16'd5 < n) begin
                w = pay_word(seq, b - 16'd5);
                d[63:16] = {w[23:16], w[31:24], w[39:32], w[47:40], w[55:48], w[63:56]};
            end
        end
        return d;
    endfunction

    assign ival     = (cfg_interval == '0) ? CNT_WIDTH'(1) : cfg_interval;
    assign fire     = cfg_enable && (timer_q == ival - CNT_WIDTH'(1));
    assign timer_d  = (!cfg_enable || fire) ? '0 : timer_q + CNT_WIDTH'(1);
    assign n_clamp  = (cfg_payload_words == 16'd0)    ? 16'd1 :
                      (cfg_payload_words > MaxWords)  ? MaxWords : cfg_payload_words;
    assign hdr_calc = build_hdr(cfg_dst_mac, cfg_src_mac, cfg_src_ip, cfg_dst_ip, cfg_src_port,
                                cfg_dst_port, seq_q[15:0], n_clamp);
    assign beat_nxt = beat_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        sent_d    = sent_q;
        overrun_d = overrun_q;
        beat_d    = beat_q;
        n_d       = n_q;
        hdr_d     = hdr_q;
        tdata_d   = tdata_q;
        tkeep_d   = tkeep_q;
        tlast_d   = tlast_q;
        tvalid_d  = tvalid_q;
        if (fire && state_q != StIdle) overrun_d = overrun_q + CNT_WIDTH'(1);
        unique case (state_q)
            StIdle: if (fire) state_d = StCalc;
            StCalc: begin
                hdr_d    = hdr_calc;
                n_d      = n_clamp;
                beat_d   = '0;
                tdata_d  = beat_data(hdr_calc, seq_q, n_clamp, 16'd0);
                tkeep_d  = 8'hFF;
                tlast_d  = 1'b0;
                tvalid_d = 1'b1;
                state_d  = StSend;
            end
            StSend: begin
                if (tvalid_q && m00_axis_tready) begin
                    if (tlast_q) begin
                        sent_d   = sent_q + CNT_WIDTH'(1);
                        seq_d    = seq_q + 64'd1;
                        tdata_d  = '0;
                        tkeep_d  = '0;
                        tlast_d  = 1'b0;
                        tvalid_d = 1'b0;
                        state_d  = StIdle;
                    end else begin
                        beat_d  = beat_nxt;
                        tdata_d = beat_data(hdr_q, seq_q, n_q, beat_nxt);
                        tlast_d = (beat_nxt == n_q + 16'd5);
                        tkeep_d = tlast_d ? 8'h03 : 8'hFF;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            seq_q     <= '0;
            sent_q    <= '0;
            overrun_q <= '0;
            beat_q    <= '0;
            n_q       <= '0;
            hdr_q     <= '0;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            tlast_q   <= 1'b0;
            tvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            seq_q     <= seq_d;
            sent_q    <= sent_d;
            overrun_q <= overrun_d;
            beat_q    <= beat_d;
            n_q       <= n_d;
            hdr_q     <= hdr_d;
            tdata_q   <= tdata_d;
            tkeep_q   <= tkeep_d;
            tlast_q   <= tlast_d;
            tvalid_q  <= tvalid_d;
        end
    end

`ifdef UDP_FRAME_GEN_STALL_STAT_EN
    logic [CNT_WIDTH-1:0] stall_q;
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            stall_q <= '0;
        end else if (tvalid_q && !m00_axis_tready) begin
            stall_q <= stall_q + CNT_WIDTH'(1);
        end
    end
    assign stat_stall = stall_q;
`endif

    assign m00_axis_tdata  = tdata_q;
    assign m00_axis_tkeep  = tkeep_q;
    assign m00_axis_tvalid = tvalid_q;
    assign m00_axis_tlast  = tlast_q;
    assign stat_sent       = sent_q;
    assign stat_overrun    = overrun_q;
    assign stat_busy       = (state_q != StIdle);

endmodule
